// File: rtl/eth_10g_tx_st_ctrl_arbiter_if.sv
// Avalon-ST bundle between the two TX sources (user data, pause/control),
// the packet-boundary arbiter and the downstream TX error adapter.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A source keeps its beat (data/sop/eop/empty/error) stable while
// valid=1 and ready=0. ready may depend combinationally on valid, but valid
// never depends on ready.
//
// Signals:
//   d_*        data source    (valid/sop/eop/data/empty/error in, ready out)
//   c_*        control source (same shape as d_*)
//   out_*      merged stream to the error adapter (out_ready from downstream)
//   pause_hold 1 = do not start new data packets
//   grant_ctrl 1 while the control source owns the output
//   orphan_err sticky flag for a non-SOP beat seen while idle
//   dbg_state  arbiter FSM state (0 IDLE, 1 GNT_D, 2 GNT_C)
//   dbg_ctrl_cnt consecutive control packets sent while data was waiting
// Modports: master = sources/downstream side, slave = arbiter.
interface eth_10g_tx_st_ctrl_arbiter_if #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int ERR_W   = 1
);
  logic               d_ready;
  logic               d_valid;
  logic               d_sop;
  logic               d_eop;
  logic [DATA_W-1:0]  d_data;
  logic [EMPTY_W-1:0] d_empty;
  logic [ERR_W-1:0]   d_error;

  logic               c_ready;
  logic               c_valid;
  logic               c_sop;
  logic               c_eop;
  logic [DATA_W-1:0]  c_data;
  logic [EMPTY_W-1:0] c_empty;
  logic [ERR_W-1:0]   c_error;

  logic               out_ready;
  logic               out_valid;
  logic               out_sop;
  logic               out_eop;
  logic [DATA_W-1:0]  out_data;
  logic [EMPTY_W-1:0] out_empty;
  logic [ERR_W-1:0]   out_error;

  logic               pause_hold;
  logic               grant_ctrl;
  logic               orphan_err;
  logic [1:0]         dbg_state;
  logic [3:0]         dbg_ctrl_cnt;

  modport master (
    input  d_ready, c_ready, out_valid, out_sop, out_eop, out_data, out_empty, out_error,
    input  grant_ctrl, orphan_err, dbg_state, dbg_ctrl_cnt,
    output d_valid, d_sop, d_eop, d_data, d_empty, d_error,
    output c_valid, c_sop, c_eop, c_data, c_empty, c_error,
    output out_ready, pause_hold
  );

  modport slave (
    output d_ready, c_ready, out_valid, out_sop, out_eop, out_data, out_empty, out_error,
    output grant_ctrl, orphan_err, dbg_state, dbg_ctrl_cnt,
    input  d_valid, d_sop, d_eop, d_data, d_empty, d_error,
    input  c_valid, c_sop, c_eop, c_data, c_empty, c_error,
    input  out_ready, pause_hold
  );
endinterface

// File: rtl/eth_10g_tx_st_ctrl_arbiter.sv
// Packet-boundary arbiter for the 10G MAC TX Avalon-ST path. Merges the user
// data stream and the pause/control frame stream into one 64-bit stream in
// front of the TX error adapter.
//
// Ports:
//   clk      TX clock, all logic on the rising edge
//   reset_n  asynchronous active-low reset
//   st       slave side of eth_10g_tx_st_ctrl_arbiter_if (both sources,
//            merged output, pause_hold, grant_ctrl, orphan_err, debug state)
//
// Control packets win over data, data is not started while pause_hold is
// high, and after MAX_CTRL_BURST control packets sent while data waits the
// next pick goes to data. The grant is registered; the output is a
// combinational mux of the granted source.
module eth_10g_tx_st_ctrl_arbiter #(
  parameter int DATA_W         = 64,
  parameter int EMPTY_W        = 3,
  parameter int ERR_W          = 1,
  parameter int MAX_CTRL_BURST = 4
) (
  input logic                        clk,
  input logic                        reset_n,
  eth_10g_tx_st_ctrl_arbiter_if.slave st
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_C = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_CTRL_BURST);

  state_t             state;
  state_t             state_nxt;
  state_t             pick;
  logic [3:0]         ctrl_cnt;
  logic [3:0]         ctrl_cnt_nxt;
  logic               orphan_q;
  logic               orphan_nxt;

  logic               d_rdy;
  logic               c_rdy;
  logic               mux_valid;
  logic               mux_sop;
  logic               mux_eop;
  logic [DATA_W-1:0]  mux_data;
  logic [EMPTY_W-1:0] mux_empty;
  logic [ERR_W-1:0]   mux_error;

  logic               d_wait;
  logic               cw;
  logic               dw;
  logic               starve;
  logic               d_eop_acc;
  logic               c_eop_acc;
  logic               orphan_seen;

  // Output mux and source readies.
  always_comb begin
    d_rdy     = 1'b0;
    c_rdy     = 1'b0;
    mux_valid = 1'b0;
    mux_sop   = 1'b0;
    mux_eop   = 1'b0;
    mux_data  = '0;
    mux_empty = '0;
    mux_error = '0;
    case (state)
      GNT_D: begin
        d_rdy     = st.out_ready;
        mux_valid = st.d_valid;
        mux_sop   = st.d_sop;
        mux_eop   = st.d_eop;
        mux_data  = st.d_data;
        mux_empty = st.d_empty;
        mux_error = st.d_error;
      end
      GNT_C: begin
        c_rdy     = st.out_ready;
        mux_valid = st.c_valid;
        mux_sop   = st.c_sop;
        mux_eop   = st.c_eop;
        mux_data  = st.c_data;
        mux_empty = st.c_empty;
        mux_error = st.c_error;
      end
      default: begin
        // Idle: a mid-packet beat with no owner is swallowed so the source
        // cannot wedge the arbiter. reset_n gating keeps ready low in reset.
        d_rdy = reset_n & st.d_valid & ~st.d_sop;
        c_rdy = reset_n & st.c_valid & ~st.c_sop;
      end
    endcase
  end

  assign d_wait      = st.d_valid & st.d_sop;
  assign cw          = st.c_valid & st.c_sop;
  assign dw          = d_wait & ~st.pause_hold;
  assign d_eop_acc   = (state == GNT_D) & st.d_valid & st.out_ready & st.d_eop;
  assign c_eop_acc   = (state == GNT_C) & st.c_valid & st.out_ready & st.c_eop;
  assign orphan_seen = (state == IDLE) &
                       ((st.d_valid & ~st.d_sop) | (st.c_valid & ~st.c_sop));

  // Burst counter and arbitration. starve looks at the count including the
  // control EOP accepted this cycle, so the MAX_CTRL_BURST-th control packet
  // is the last one before waiting data is served.
  always_comb begin
    ctrl_cnt_nxt = ctrl_cnt;
    if (d_eop_acc) begin
      ctrl_cnt_nxt = '0;
    end else if (c_eop_acc) begin
      if (!d_wait) begin
        ctrl_cnt_nxt = '0;
      end else if (ctrl_cnt < MAX_CNT) begin
        ctrl_cnt_nxt = ctrl_cnt + 4'd1;
      end
    end

    starve = (ctrl_cnt_nxt == MAX_CNT);

    // cw/dw are taken straight from the source pins, including a beat being
    // accepted this cycle: a single-beat packet keeps the grant for its
    // source's next packet.
    if (dw && starve) begin
      pick = GNT_D;
    end else if (cw) begin
      pick = GNT_C;
    end else if (dw) begin
      pick = GNT_D;
    end else begin
      pick = IDLE;
    end

    state_nxt = state;
    if (state == IDLE || d_eop_acc || c_eop_acc) begin
      state_nxt = pick;
    end

    orphan_nxt = orphan_q | orphan_seen;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ctrl_cnt <= '0;
      orphan_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl_cnt <= ctrl_cnt_nxt;
      orphan_q <= orphan_nxt;
    end
  end

  assign st.d_ready      = d_rdy;
  assign st.c_ready      = c_rdy;
  assign st.out_valid    = mux_valid;
  assign st.out_sop      = mux_sop;
  assign st.out_eop      = mux_eop;
  assign st.out_data     = mux_data;
  assign st.out_empty    = mux_empty;
  assign st.out_error    = mux_error;
  assign st.grant_ctrl   = (state == GNT_C);
  assign st.orphan_err   = orphan_q;
  assign st.dbg_state    = state;
  assign st.dbg_ctrl_cnt = ctrl_cnt;

endmodule

// File: tb/tb_eth_10g_tx_st_ctrl_arbiter.sv
// Bench for eth_10g_tx_st_ctrl_arbiter: directed timing cases plus a random
// two-source run scored against per-source expected queues. Beat data carries
// its source in the top bit and a non-zero packet id.
module tb_eth_10g_tx_st_ctrl_arbiter;

  localparam int DATA_W         = 64;
  localparam int EMPTY_W        = 3;
  localparam int ERR_W          = 1;
  localparam int MAX_CTRL_BURST = 4;
  localparam int BW             = 2 + EMPTY_W + ERR_W + DATA_W;
  localparam int ACC_LIMIT      = 3000;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_D = 2'd1;
  localparam logic [1:0] S_GNT_C = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  eth_10g_tx_st_ctrl_arbiter_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .ERR_W(ERR_W)) bus ();

  eth_10g_tx_st_ctrl_arbiter #(
    .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .ERR_W(ERR_W), .MAX_CTRL_BURST(MAX_CTRL_BURST)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .st     (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_d_q[$];
  logic [BW-1:0] exp_c_q[$];
  bit            order_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            peak_cnt = 0;
  int            beats_d_out = 0;
  int            pkt_id = 0;
  bit            in_pkt = 0;
  bit            cur_src = 0;
  bit            t5_run = 0;
  bit            test_done = 0;
  logic [BW-1:0] mon_beat;
  bit            mon_src;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(input logic sop, input logic eop,
                                         input logic [EMPTY_W-1:0] empty,
                                         input logic [ERR_W-1:0] err,
                                         input logic [DATA_W-1:0] data);
    return {sop, eop, empty, err, data};
  endfunction

  function automatic logic [79:0] all_outs();
    return {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_empty, bus.out_error,
            bus.out_data, bus.d_ready, bus.c_ready, bus.grant_ctrl, bus.orphan_err};
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (int'(bus.dbg_ctrl_cnt) > peak_cnt) peak_cnt = int'(bus.dbg_ctrl_cnt);
      if (bus.out_valid && bus.out_ready) begin
        mon_beat = {bus.out_sop, bus.out_eop, bus.out_empty, bus.out_error, bus.out_data};
        mon_src  = bus.out_data[DATA_W-1];
        check("grant_matches_src", bus.grant_ctrl, mon_src);
        if (in_pkt) check("pkt_interleave", mon_src, cur_src);
        if (bus.out_sop) order_q.push_back(mon_src);
        if (mon_src) begin
          if (exp_c_q.size() == 0) check("sb_underflow_c", mon_beat, '0);
          else check("beat_c", mon_beat, exp_c_q.pop_front());
        end else begin
          beats_d_out++;
          if (exp_d_q.size() == 0) check("sb_underflow_d", mon_beat, '0);
          else check("beat_d", mon_beat, exp_d_q.pop_front());
        end
        in_pkt  = !bus.out_eop;
        cur_src = mon_src;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    bus.d_valid = 0; bus.d_sop = 0; bus.d_eop = 0; bus.d_data = '0; bus.d_empty = '0; bus.d_error = '0;
    bus.c_valid = 0; bus.c_sop = 0; bus.c_eop = 0; bus.c_data = '0; bus.c_empty = '0; bus.c_error = '0;
    bus.out_ready = 0;
    bus.pause_hold = 0;
    reset_n = 0;
    exp_d_q.delete();
    exp_c_q.delete();
    order_q.delete();
    in_pkt = 0;
    peak_cnt = 0;
    beats_d_out = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", all_outs(), '0);
    check("rst_state", bus.dbg_state, S_IDLE);
    check("rst_ctrl_cnt", bus.dbg_ctrl_cnt, 4'd0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Presents one beat (call at posedge+1) and returns at posedge+1 after it
  // has been accepted, with valid dropped.
  task automatic drive_beat(input bit src, input logic sop, input logic eop,
                            input logic [EMPTY_W-1:0] empty, input logic [ERR_W-1:0] err,
                            input logic [DATA_W-1:0] data);
    int waited = 0;
    bit done = 0;
    if (src) begin
      bus.c_valid = 1; bus.c_sop = sop; bus.c_eop = eop;
      bus.c_empty = empty; bus.c_error = err; bus.c_data = data;
      exp_c_q.push_back(pack(sop, eop, empty, err, data));
    end else begin
      bus.d_valid = 1; bus.d_sop = sop; bus.d_eop = eop;
      bus.d_empty = empty; bus.d_error = err; bus.d_data = data;
      exp_d_q.push_back(pack(sop, eop, empty, err, data));
    end
    while (!done) begin
      @(negedge clk);
      if ((src ? bus.c_ready : bus.d_ready) === 1'b1) done = 1;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited >= ACC_LIMIT) begin
          check(src ? "c_accept_timeout" : "d_accept_timeout", 80'(waited), 80'(ACC_LIMIT - 1));
          done = 1;
        end
      end
    end
    if (src) bus.c_valid = 0;
    else bus.d_valid = 0;
  endtask

  task automatic send_pkt(input bit src, input int nbeats, input int last_empty, input int gap_max);
    int id;
    logic [DATA_W-1:0] d;
    id = pkt_id;
    pkt_id++;
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
      d = {src, 15'(id + 1), 16'(b), 32'($urandom)};
      drive_beat(src, b == 0, b == nbeats - 1,
                 (b == nbeats - 1) ? EMPTY_W'(last_empty) : '0,
                 ERR_W'($urandom_range(1, 0)), d);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    check("watchdog_done", test_done, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- tests ----------------
  initial begin
    int bad;
    logic [6:0] ord;

    // T1: single 3-beat data packet, grant one cycle after arrival.
    do_reset();
    bus.out_ready = 1;
    fork
      send_pkt(0, 3, 5, 0);
      begin
        @(negedge clk);
        check("t1_idle_on_arrival", {bus.dbg_state, bus.out_valid, bus.d_ready}, {S_IDLE, 2'b00});
        @(negedge clk);
        check("t1_gnt_d", bus.dbg_state, S_GNT_D);
        check("t1_first_beat", {bus.out_valid, bus.out_sop, bus.grant_ctrl}, 3'b110);
        @(negedge clk);
        @(negedge clk);
        check("t1_eop_empty", {bus.out_valid, bus.out_eop, bus.out_empty}, {2'b11, 3'd5});
        @(negedge clk);
        check("t1_back_idle", {bus.dbg_state, bus.out_valid}, {S_IDLE, 1'b0});
      end
    join
    check("t1_d_beats", beats_d_out, 3);

    // T2: data and control SOP together, control first, no idle gap.
    do_reset();
    bus.out_ready = 1;
    fork
      send_pkt(1, 2, 3, 0);
      send_pkt(0, 2, 1, 0);
      begin
        @(negedge clk);
        check("t2_idle", bus.dbg_state, S_IDLE);
        @(negedge clk);
        check("t2_gnt_c", {bus.dbg_state, bus.grant_ctrl, bus.out_sop}, {S_GNT_C, 2'b11});
        @(negedge clk);
        check("t2_c_eop", {bus.grant_ctrl, bus.out_eop, bus.d_ready}, 3'b110);
        @(negedge clk);
        check("t2_d_follows", {bus.dbg_state, bus.grant_ctrl, bus.out_valid, bus.out_sop},
              {S_GNT_D, 3'b011});
        check("t2_ctrl_cnt", bus.dbg_ctrl_cnt, 4'd1);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("t2_pkts", order_q.size(), 2);
    if (order_q.size() == 2) check("t2_order", {order_q[0], order_q[1]}, 2'b10);
    check("t2_cnt_cleared", bus.dbg_ctrl_cnt, 4'd0);

    // T3: six back-to-back 1-beat control packets with data waiting.
    do_reset();
    bus.out_ready = 1;
    fork
      begin
        for (int i = 0; i < 6; i++) send_pkt(1, 1, 0, 0);
      end
      send_pkt(0, 1, 2, 0);
    join
    repeat (2) @(posedge clk);
    #1;
    check("t3_pkts", order_q.size(), 7);
    ord = '0;
    for (int i = 0; i < order_q.size() && i < 7; i++) ord[6-i] = order_q[i];
    check("t3_order", ord, 7'b1111011);
    check("t3_peak_cnt", peak_cnt, MAX_CTRL_BURST);

    // T4: pause_hold holds off a waiting data packet, then a pause raised
    // mid-packet does not truncate the packet.
    do_reset();
    bus.out_ready = 1;
    bus.pause_hold = 1;
    fork
      send_pkt(0, 3, 4, 0);
      begin
        bad = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (bus.d_ready !== 1'b0 || bus.dbg_state !== S_IDLE) bad++;
        end
        check("t4_held_cycles_bad", bad, 0);
        @(posedge clk);
        #1;
        bus.pause_hold = 0;
        @(negedge clk);
        check("t4_release_idle", {bus.dbg_state, bus.d_ready}, {S_IDLE, 1'b0});
        @(negedge clk);
        check("t4_release_gnt", {bus.dbg_state, bus.out_valid, bus.out_sop}, {S_GNT_D, 2'b11});
      end
    join
    beats_d_out = 0;
    fork
      send_pkt(0, 4, 2, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.pause_hold = 1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("t4_mid_pause_beats", beats_d_out, 4);
    check("t4_mid_pause_idle", bus.dbg_state, S_IDLE);
    bus.pause_hold = 0;

    // T5: 200 mixed packets under random backpressure and pause.
    do_reset();
    t5_run = 1;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 100; i++)
              send_pkt(0, $urandom_range(5, 2), $urandom_range(7, 0), 2);
          end
          begin
            for (int i = 0; i < 100; i++)
              send_pkt(1, $urandom_range(5, 2), $urandom_range(7, 0), 2);
          end
        join
        t5_run = 0;
      end
      begin
        while (t5_run) begin
          bus.out_ready = 1'($urandom_range(1, 0));
          bus.pause_hold = ($urandom_range(9, 0) == 0);
          @(posedge clk);
          #1;
        end
      end
    join
    bus.out_ready = 1;
    bus.pause_hold = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_d_left", exp_d_q.size(), 0);
    check("t5_c_left", exp_c_q.size(), 0);
    check("t5_pkts", order_q.size(), 200);
    check("t5_no_orphan", bus.orphan_err, 1'b0);

    // T6: orphan beat in idle, then async reset mid control packet.
    do_reset();
    bus.out_ready = 1;
    bus.d_valid = 1;
    bus.d_sop = 0;
    bus.d_eop = 0;
    bus.d_data = 64'h0123_4567_89ab_cdef;
    @(negedge clk);
    check("t6_orphan_ready", {bus.d_ready, bus.out_valid, bus.orphan_err}, 3'b100);
    @(posedge clk);
    #1;
    bus.d_valid = 0;
    check("t6_orphan_set", {bus.orphan_err, bus.dbg_state}, {1'b1, S_IDLE});
    repeat (3) @(posedge clk);
    #1;
    check("t6_orphan_sticky", bus.orphan_err, 1'b1);
    drive_beat(1, 1, 0, 0, 0, {1'b1, 15'h7ff0, 16'd0, 32'h1111_2222});
    bus.c_valid = 1; bus.c_sop = 0; bus.c_eop = 0;
    bus.c_empty = 0; bus.c_error = 0; bus.c_data = {1'b1, 15'h7ff0, 16'd1, 32'h3333_4444};
    exp_c_q.push_back(pack(1'b0, 1'b0, '0, '0, bus.c_data));
    @(negedge clk);
    check("t6_mid_pkt_gnt", {bus.dbg_state, bus.c_ready}, {S_GNT_C, 1'b1});
    #2;
    reset_n = 0;
    #1;
    check("t6_async_outputs", all_outs(), '0);
    check("t6_async_state", {bus.dbg_state, bus.dbg_ctrl_cnt}, '0);
    bus.c_valid = 0;
    do_reset();
    check("t6_after_reset_idle", {bus.dbg_state, bus.orphan_err}, {S_IDLE, 1'b0});

    test_done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
